// File: rtl/des_decrypt_core_pkg.sv
// ============================================================================
// Module      : des_decrypt_core_pkg
// Description : DES tables, state encoding and bit-permutation helpers shared
//               by the iterative decryption core and its Feistel round.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package des_decrypt_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [4:0]  c_LAST_ROUND  = 5'd16;

    localparam logic [63:0] c_KAT_KEY     = 64'h133457799BBCDFF1;
    localparam logic [63:0] c_KAT_CIPHER  = 64'h85E813540F0AB405;
    localparam logic [63:0] c_KAT_PLAIN   = 64'h0123456789ABCDEF;
    localparam logic [63:0] c_ZERO_CIPHER = 64'h8CA64DE9C1B123A7;

    // All tables use DES numbering: entry n selects source bit n, bit 1 = MSB.
    localparam int c_IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

    localparam int c_FP_TAB [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

    localparam int c_PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int c_PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int c_E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int c_P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int c_SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - c_IP_TAB[i])];
        return o;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - c_FP_TAB[i])];
        return o;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) o[6'(55 - i)] = x[6'(64 - c_PC1_TAB[i])];
        return o;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = x[6'(56 - c_PC2_TAB[i])];
        return o;
    endfunction

    function automatic logic [47:0] expand(input logic [31:0] x);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = x[5'(32 - c_E_TAB[i])];
        return o;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 32; i++) o[5'(31 - i)] = x[5'(32 - c_P_TAB[i])];
        return o;
    endfunction

    // Row is the outer bit pair, column the inner four bits of each 6-bit group.
    function automatic logic [31:0] sbox_sub(input logic [47:0] x);
        logic [31:0] o;
        logic [5:0]  six;
        o = '0;
        for (int b = 0; b < 8; b++) begin
            six = x[6'(47 - 6 * b) -: 6];
            o[5'(31 - 4 * b) -: 4] = 4'(c_SBOX[b][{six[5], six[0], six[4:1]}]);
        end
        return o;
    endfunction

    // Decrypt schedule: right-rotate 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 before rounds 1..16.
    function automatic logic [1:0] rot_amount(input logic [4:0] round_idx);
        case (round_idx)
            5'd1:                 return 2'd0;
            5'd2, 5'd9, 5'd16:    return 2'd1;
            default:              return 2'd2;
        endcase
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/des_decrypt_core_round.sv
// ============================================================================
// Module      : des_round
// Description : One combinational DES Feistel round: L' = R, R' = L ^ f(R, K).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module des_round
    import des_decrypt_core_pkg::*;
(
    input  logic [31:0] i_l,
    input  logic [31:0] i_r,
    input  logic [47:0] i_k,
    output logic [31:0] o_l,
    output logic [31:0] o_r
);

    logic [47:0] w_mixed;
    logic [31:0] w_subst;
    logic [31:0] w_f;

    assign w_mixed = expand(i_r) ^ i_k;
    assign w_subst = sbox_sub(w_mixed);
    assign w_f     = perm_p(w_subst);

    assign o_l = i_r;
    assign o_r = i_l ^ w_f;

endmodule

`default_nettype wire

// File: rtl/des_decrypt_core.sv
// ============================================================================
// Module      : des_decrypt_core
// Description : Iterative DES decryption, one Feistel round per clock with
//               reverse-order subkeys generated on the fly.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module des_decrypt_core
    import des_decrypt_core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] key,
    input  logic [63:0] cipher,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plain,
    output logic        busy
);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [4:0]  r_cnt;
    logic [63:0] r_plain;

    logic [63:0] w_ip;
    logic [55:0] w_cd;
    logic [1:0]  w_rot;
    logic [27:0] w_c_rot;
    logic [27:0] w_d_rot;
    logic [47:0] w_subkey;
    logic [31:0] w_l_next;
    logic [31:0] w_r_next;
    logic        w_accept;
    logic        w_last;

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_last   = (r_cnt == c_LAST_ROUND);

    assign w_ip     = perm_ip(cipher);
    assign w_cd     = perm_pc1(key);

    // Rotation is applied combinationally so round 1 sees the unrotated C/D.
    assign w_rot    = rot_amount(r_cnt);
    assign w_c_rot  = rotr28(r_c, w_rot);
    assign w_d_rot  = rotr28(r_d, w_rot);
    assign w_subkey = perm_pc2({w_c_rot, w_d_rot});

    des_round u_round (
        .i_l (r_l),
        .i_r (r_r),
        .i_k (w_subkey),
        .o_l (w_l_next),
        .o_r (w_r_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid)  w_state_next = ST_ROUND;
            ST_ROUND: if (w_last)    w_state_next = ST_DONE;
            ST_DONE:  if (out_ready) w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_l     <= '0;
            r_r     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_plain <= '0;
        end else if (w_accept) begin
            r_l     <= w_ip[63:32];
            r_r     <= w_ip[31:0];
            r_c     <= w_cd[55:28];
            r_d     <= w_cd[27:0];
            r_cnt   <= 5'd1;
        end else if (r_state == ST_ROUND) begin
            r_l     <= w_l_next;
            r_r     <= w_r_next;
            r_c     <= w_c_rot;
            r_d     <= w_d_rot;
            if (w_last) begin
                // Final swap undone: preoutput is R16 || L16.
                r_plain <= perm_fp({w_r_next, w_l_next});
            end else begin
                r_cnt   <= r_cnt + 5'd1;
            end
        end else if ((r_state == ST_DONE) && out_ready) begin
            r_cnt   <= '0;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_ROUND);
    assign plain     = r_plain;

endmodule

`default_nettype wire
